// File: rtl/counter_updown_nbit.sv
// counter_updown_nbit: WIDTH-bit up/down counter spanning 0..MAX_VAL.
// Supports wrap or saturate at the terminal value, synchronous clear and
// clamped parallel load. It also provides a cascade carry/borrow, a wrap
// pulse and a sticky overflow flag.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset (loads RST_VAL, clears flags)
//   clr       synchronous clear to RST_VAL, also clears ovf
//   ld        synchronous parallel load of data_in (clamped to MAX_VAL)
//   data_in   load value
//   en        count enable / cascade carry-in
//   up        direction: 1 = increment, 0 = decrement
//   data_out  registered count
//   tc        combinational terminal indicator for the current direction
//   cout      combinational cascade carry/borrow (en & tc)
//   wrap      registered pulse, high the cycle after a wrap event
//   ovf       registered sticky flag: a count past the terminal was attempted
module counter_updown_nbit #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             cout,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;

  // Terminal depends on direction so a cascade borrows at 0 and carries at MAX_VAL
  always_comb begin
    tc   = up ? (data_out == MAX_VAL) : (data_out == '0);
    cout = en & tc;
  end

  // Next-state: clr > ld > en > hold; wrap is asserted only on a wrap event
  always_comb begin
    cnt_nxt  = data_out;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf;
    if (clr) begin
      cnt_nxt = RST_VAL;
      ovf_nxt = 1'b0;
    end else if (ld) begin
      cnt_nxt = (data_in > MAX_VAL) ? MAX_VAL : data_in;
    end else if (en) begin
      if (tc) begin
        ovf_nxt = 1'b1;
        if (!SATURATE) begin
          cnt_nxt  = up ? '0 : MAX_VAL;
          wrap_nxt = 1'b1;
        end
      end else begin
        cnt_nxt = up ? (data_out + WIDTH'(1)) : (data_out - WIDTH'(1));
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= RST_VAL;
      wrap     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      data_out <= cnt_nxt;
      wrap     <= wrap_nxt;
      ovf      <= ovf_nxt;
    end
  end

endmodule
